mac_result_drain: RTL and testbench
===================================

Name: mac_result_drain

Overview:
Read-side companion to the MAC processing-element row. When the array controller signals that accumulation is complete, it snapshots the N accumulator outputs (ACC_W each) into a shadow buffer and pulses clear to the PEs so the next tile can start at once. It then streams the captured results, saturated to OUT_W, over a valid/ready interface to the writeback path.

Parameters:
N, 4, number of PE accumulators drained (array columns); N >= 2.
ACC_W, 33, PE accumulator width (signed).
OUT_W, 32, output word width (signed); OUT_W <= ACC_W.
IDX_W, $clog2(N), width of the word index.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
done  in  1  single-cycle pulse: PE accumulators hold final tile results this cycle.
acc_flat  in  N*ACC_W  PE c_out values, PE k at bits [k*ACC_W +: ACC_W], signed.
pe_clear  out  1  one-cycle clear to all PEs.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accepts word.
m_data  out  OUT_W  saturated result, signed.
m_idx  out  IDX_W  PE index of m_data.
m_last  out  1  high with m_idx == N-1.
m_sat  out  1  m_data was saturated.
busy  out  1  high in DRAIN.
drop_err  out  1  sticky: a done pulse was rejected.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; idx 0; m_valid, pe_clear, busy, drop_err all 0; shadow buffer all 0. Reset in mid-drain aborts the drain. Words not yet transferred are discarded. pe_clear is not issued.
- States: IDLE, DRAIN.
- Accept condition: accept = done & (state==IDLE | (m_valid & m_ready & m_last)).
- On accept at edge t:
  - Capture all N words of acc_flat into the buffer.
  - Set idx to 0 and go to DRAIN.
  - pe_clear is 1 for exactly the cycle after t.
  - m_valid is 1 from the cycle after t.
  - Latency from done to first valid word: 1 cycle.
- DRAIN: m_valid=1, busy=1.
  - m_data = sat(buf[idx]); m_idx = idx; m_last = (idx==N-1).
  - Outputs are combinational from the registered buffer and idx, and hold stable while m_ready is 0.
- Handshake (m_valid & m_ready):
  - If idx < N-1: idx increments.
  - If idx == N-1: go to IDLE and m_valid drops next cycle, unless accept is also true that cycle. In that case, back-to-back: new capture, idx=0, stay in DRAIN, m_valid stays 1, pe_clear pulses.
- Rejected done: done while in DRAIN that is not on the final handshake. drop_err is set (sticky until reset), the buffer is unchanged, and no pe_clear is issued.
- done while in IDLE is always accepted.
- Saturation, with MAX = 2^(OUT_W-1)-1 and MIN = -2^(OUT_W-1):
  - v > MAX gives MAX and m_sat=1.
  - v < MIN gives MIN and m_sat=1.
  - Otherwise v[OUT_W-1:0] and m_sat=0.
  - With OUT_W == ACC_W, saturation never fires.
- Throughput: with m_ready held high, one word per cycle; N words take N cycles after the done cycle.
- No combinational path from m_ready to m_valid or m_data.

Decomposition:
- Shared package mac_pkg:
  - state enum {IDLE, DRAIN};
  - localparams ACC_W=33 and OUT_W=32 (shared with the PE);
  - function sat_acc(ACC_W→OUT_W), which returns value plus flag.
- One sub-module: acc_saturate (combinational ACC_W→OUT_W clamp plus flag), instantiated once on the buffer read mux.

Test Plan:
- Basic drain: reset, N=4, acc_flat={PE0=5, PE1=-7, PE2=0, PE3=1000}, done pulse, m_ready=1.
  → pe_clear=1 the next cycle only; m_idx 0..3 on 4 consecutive cycles with m_data 5, -7, 0, 1000; m_last on idx 3; m_valid=0 after.
- Backpressure: same data, m_ready toggling 1,0,0,1,1,0,1.
  → m_data/m_idx stable while stalled; the 4 words arrive in order; no duplicates.
- Saturation: PE0=33'h0_FFFF_FFFF (+2^32-1), PE1=33'h1_0000_0000 (-2^32), PE2=2^31-1, PE3=-2^31.
  → m_data 7FFF_FFFF with m_sat=1; 8000_0000 with m_sat=1; 7FFF_FFFF with m_sat=0; 8000_0000 with m_sat=0.
- Back-to-back: second done on the same cycle as the m_last handshake, with new acc_flat={1,2,3,4}.
  → m_valid never drops; pe_clear pulses again; the next words are 1,2,3,4; drop_err stays 0.
- Rejected done: done while idx=1 with m_ready=0.
  → drop_err=1; the buffer is unchanged (remaining words are the original PE1..PE3); no extra pe_clear.
- Reset mid-drain: rst_n low for 1 cycle at idx=2.
  → next cycle m_valid=0, busy=0, drop_err=0, pe_clear=0; a following done starts the drain at idx 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC processing-element row and its result drain.
//   ACC_W / OUT_W : PE accumulator width and writeback word width (both signed).
//   state_e       : drain controller states.
//   sat_acc()     : signed clamp of an ACC_W accumulator to OUT_W, with a saturation flag.
package mac_pkg;

  localparam int unsigned ACC_W = 33;
  localparam int unsigned OUT_W = 32;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [OUT_W-1:0] value;
    logic             sat;
  } sat_res_t;

  // The value fits when every bit from the OUT_W sign bit upward matches the accumulator sign.
  function automatic sat_res_t sat_acc(input logic [ACC_W-1:0] v);
    sat_res_t                 res;
    logic     [ACC_W-OUT_W:0] top;
    top = v[ACC_W-1:OUT_W-1];
    if ((top == '0) || (top == '1)) begin
      res.value = v[OUT_W-1:0];
      res.sat   = 1'b0;
    end else if (v[ACC_W-1]) begin
      res.value = {1'b1, {(OUT_W-1){1'b0}}};
      res.sat   = 1'b1;
    end else begin
      res.value = {1'b0, {(OUT_W-1){1'b1}}};
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_saturate.sv
// Combinational signed clamp from an ACC_W accumulator value to an OUT_W word.
// Ports:
//   acc  : signed accumulator value
//   data : clamped value (MAX/MIN on overflow, low OUT_W bits otherwise)
//   sat  : high when clamping occurred
module acc_saturate #(
  parameter int unsigned ACC_W = mac_pkg::ACC_W,
  parameter int unsigned OUT_W = mac_pkg::OUT_W
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam int unsigned TopW = ACC_W - OUT_W + 1;

  logic [TopW-1:0] top;

  // With OUT_W == ACC_W the top slice is a single bit, so the fits test is always true.
  always_comb begin
    top  = acc[ACC_W-1:OUT_W-1];
    data = acc[OUT_W-1:0];
    sat  = 1'b0;
    if (!((top == '0) || (top == '1))) begin
      sat = 1'b1;
      if (acc[ACC_W-1]) begin
        data = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        data = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Result drain for the MAC PE row. On an accepted done pulse it snapshots all N accumulators
// into a shadow buffer, pulses pe_clear for one cycle and streams the saturated words out over
// a valid/ready interface, one per handshake, in PE index order.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   done              : tile complete pulse
//   acc_flat          : N packed signed accumulators, PE k at [k*ACC_W +: ACC_W]
//   pe_clear          : one-cycle clear to the PEs after each capture
//   m_valid / m_ready : output handshake
//   m_data, m_idx     : saturated word and its PE index
//   m_last, m_sat     : final word of tile, word was clamped
//   busy              : draining
//   drop_err          : sticky, a done pulse arrived while the buffer was still in use
module mac_result_drain #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = mac_pkg::ACC_W,
  parameter int unsigned OUT_W = mac_pkg::OUT_W,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               done,
  input  logic [N*ACC_W-1:0] acc_flat,
  output logic               pe_clear,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [IDX_W-1:0]   m_idx,
  output logic               m_last,
  output logic               m_sat,
  output logic               busy,
  output logic               drop_err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  mac_pkg::state_e  state_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] buf_q [N];
  logic             pe_clear_q;
  logic             drop_err_q;

  logic             draining;
  logic             last;
  logic             xfer;
  logic             accept;
  logic [ACC_W-1:0] rd_word;

  assign draining = (state_q == mac_pkg::DRAIN);
  assign last     = (idx_q == LastIdx);
  assign xfer     = draining & m_ready;
  // A new tile may land on the cycle the final word leaves, keeping the stream gapless.
  assign accept   = done & (!draining | (m_ready & last));
  assign rd_word  = buf_q[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= mac_pkg::IDLE;
      idx_q      <= '0;
      pe_clear_q <= 1'b0;
      drop_err_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      pe_clear_q <= accept;
      if (done && !accept) begin
        drop_err_q <= 1'b1;
      end
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          buf_q[k] <= acc_flat[k*ACC_W +: ACC_W];
        end
        idx_q   <= '0;
        state_q <= mac_pkg::DRAIN;
      end else if (xfer) begin
        if (last) begin
          state_q <= mac_pkg::IDLE;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  acc_saturate #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc  (rd_word),
    .data (m_data),
    .sat  (m_sat)
  );

  assign m_valid  = draining;
  assign busy     = draining;
  assign m_idx    = idx_q;
  assign m_last   = last;
  assign pe_clear = pe_clear_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

  localparam int N     = 4;
  localparam int ACC_W = 33;
  localparam int OUT_W = 32;
  localparam int IDX_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               done;
  logic [N*ACC_W-1:0] acc_flat;
  logic               pe_clear;
  logic               m_valid;
  logic               m_ready;
  logic [OUT_W-1:0]   m_data;
  logic [IDX_W-1:0]   m_idx;
  logic               m_last;
  logic               m_sat;
  logic               busy;
  logic               drop_err;

  always #5 clk = ~clk;

  mac_result_drain #(
    .N     (N),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done     (done),
    .acc_flat (acc_flat),
    .pe_clear (pe_clear),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_idx    (m_idx),
    .m_last   (m_last),
    .m_sat    (m_sat),
    .busy     (busy),
    .drop_err (drop_err)
  );

  // Reference: the words still owed to the writeback path for the current tile.
  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          sat;
  } word_t;

  word_t q[$];
  bit    pe_clear_exp;
  bit    drop_exp;
  int    n_checks;
  int    n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic word_t model_word(input logic [32:0] x, input int k);
    word_t  w;
    longint v;
    v     = {{31{x[32]}}, x};
    w.idx = k;
    if (v > 64'sd2147483647) begin
      w.data = 32'h7FFF_FFFF;
      w.sat  = 1'b1;
    end else if (v < -64'sd2147483648) begin
      w.data = 32'h8000_0000;
      w.sat  = 1'b1;
    end else begin
      w.data = v[31:0];
      w.sat  = 1'b0;
    end
    return w;
  endfunction

  function automatic logic [N*ACC_W-1:0] pack(input longint v0, input longint v1,
                                              input longint v2, input longint v3);
    logic [N*ACC_W-1:0] r;
    r[0*ACC_W +: ACC_W] = v0[32:0];
    r[1*ACC_W +: ACC_W] = v1[32:0];
    r[2*ACC_W +: ACC_W] = v2[32:0];
    r[3*ACC_W +: ACC_W] = v3[32:0];
    return r;
  endfunction

  function automatic longint rand_acc();
    longint r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(3))
      0:       return longint'($urandom_range(2000)) - 1000;
      1:       return r;
      2:       return 64'sd2147483647 + longint'($urandom_range(4)) - 2;
      default: return -64'sd2147483648 + longint'($urandom_range(4)) - 2;
    endcase
  endfunction

  task automatic check_outputs();
    check_eq("m_valid", m_valid, q.size() != 0);
    check_eq("busy", busy, q.size() != 0);
    check_eq("pe_clear", pe_clear, pe_clear_exp);
    check_eq("drop_err", drop_err, drop_exp);
    if (q.size() != 0) begin
      check_eq("m_data", m_data, q[0].data);
      check_eq("m_idx", m_idx, q[0].idx);
      check_eq("m_last", m_last, q[0].idx == N - 1);
      check_eq("m_sat", m_sat, q[0].sat);
    end
  endtask

  // Called at a falling edge: check, drive, let the rising edge happen, advance the model.
  task automatic cycle(input bit rst, input bit d, input logic [N*ACC_W-1:0] a, input bit rdy);
    bit was_idle;
    bit hs;
    bit hs_last;
    bit accept;
    check_outputs();
    rst_n    = !rst;
    done     = d;
    acc_flat = a;
    m_ready  = rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      pe_clear_exp = 1'b0;
      drop_exp     = 1'b0;
    end else begin
      was_idle = (q.size() == 0);
      hs       = !was_idle && rdy;
      hs_last  = hs && (q[0].idx == N - 1);
      accept   = d && (was_idle || hs_last);
      if (hs) void'(q.pop_front());
      pe_clear_exp = accept;
      if (accept) begin
        q.delete();
        for (int k = 0; k < N; k++) q.push_back(model_word(a[k*ACC_W +: ACC_W], k));
      end else if (d) begin
        drop_exp = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, rdy);
  endtask

  logic [N*ACC_W-1:0] basic;
  logic [N*ACC_W-1:0] satv;
  logic [N*ACC_W-1:0] seq;
  bit                 bp[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    done     = 1'b0;
    m_ready  = 1'b0;
    acc_flat = '0;
    basic    = pack(5, -7, 0, 1000);
    satv     = pack(64'h0_FFFF_FFFF, 64'h1_0000_0000, 64'sd2147483647, -64'sd2147483648);
    seq      = pack(1, 2, 3, 4);
    @(negedge clk);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check_eq("reset_valid", m_valid, 1'b0);
    check_eq("reset_drop", drop_err, 1'b0);

    // Basic drain at full rate
    cycle(1'b0, 1'b1, basic, 1'b1);
    check_eq("basic_first", m_data, 32'd5);
    check_eq("basic_clear", pe_clear, 1'b1);
    idle(6, 1'b1);

    // Backpressure
    cycle(1'b0, 1'b1, basic, 1'b0);
    foreach (bp[i]) cycle(1'b0, 1'b0, '0, bp[i]);
    idle(4, 1'b1);

    // Saturation
    cycle(1'b0, 1'b1, satv, 1'b0);
    check_eq("sat_pos", m_data, 32'h7FFF_FFFF);
    check_eq("sat_pos_flag", m_sat, 1'b1);
    idle(6, 1'b1);

    // Back-to-back: second done lands on the final handshake
    cycle(1'b0, 1'b1, satv, 1'b1);
    idle(3, 1'b1);
    cycle(1'b0, 1'b1, seq, 1'b1);
    check_eq("b2b_first", m_data, 32'd1);
    check_eq("b2b_clear", pe_clear, 1'b1);
    idle(6, 1'b1);

    // Rejected done at idx 1 while stalled
    cycle(1'b0, 1'b1, basic, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, seq, 1'b0);
    check_eq("rej_drop", drop_err, 1'b1);
    check_eq("rej_data", m_data, 32'hFFFF_FFF9);
    check_eq("rej_noclear", pe_clear, 1'b0);
    idle(6, 1'b1);

    // Reset mid-drain at idx 2
    cycle(1'b0, 1'b1, seq, 1'b1);
    idle(2, 1'b1);
    check_eq("pre_rst_idx", m_idx, 2'd2);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check_eq("post_rst_valid", m_valid, 1'b0);
    check_eq("post_rst_drop", drop_err, 1'b0);
    cycle(1'b0, 1'b1, basic, 1'b0);
    check_eq("restart_idx", m_idx, 2'd0);
    idle(6, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(5) == 0,
            pack(rand_acc(), rand_acc(), rand_acc(), rand_acc()),
            $urandom_range(3) != 0);
    end
    idle(8, 1'b1);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
